// File: rtl/uart_tx_buffer.sv
// uart_tx_buffer: byte FIFO between the RAM MMIO UART write and the UART
// AXI-stream input, with optional LF to CR LF expansion on the wire.
module uart_tx_buffer #(
  parameter int DEPTH = 16,
  parameter bit CRLF  = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk_en,
  input  logic [7:0]               i_wr_data,
  input  logic                     i_wr_en,
  input  logic                     i_flush,
  output logic [7:0]               o_data,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty,
  output logic                     o_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {SEND, CR_DONE} state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem_q [DEPTH];
  logic [7:0]      mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;

  logic [7:0]      head;
  logic            cr_emit;
  logic            hs;
  logic            pop;
  logic            wr_req;
  logic            push;

  assign head       = mem_q[rd_ptr_q];
  assign o_count    = count_q;
  assign o_full     = (count_q == FULL_CNT);
  assign o_empty    = (count_q == '0);
  assign o_overflow = ovf_q;

  // CRLF state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= SEND;
    else      state_q <= state_d;
  end

  // CRLF next state: a LF head first sends CR, then the LF itself
  always_comb begin
    state_d = state_q;
    if (i_flush)      state_d = SEND;
    else if (hs)      state_d = cr_emit ? CR_DONE : SEND;
  end

  // Stream outputs and handshake decode; CR_DONE leaves the LF at head
  always_comb begin
    o_valid = !o_empty;
    cr_emit = CRLF && (state_q == SEND) && (head == 8'h0A);
    if (!o_valid)     o_data = 8'h00;
    else if (cr_emit) o_data = 8'h0D;
    else              o_data = head;
    hs  = o_valid && i_ready;
    pop = hs && !cr_emit;
  end

  // FIFO next state; flush beats everything, a pop frees a slot when full
  always_comb begin
    wr_req   = i_wr_en && clk_en;
    push     = wr_req && (!o_full || pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q || (wr_req && !push);
    if (push) begin
      mem_d[wr_ptr_q] = i_wr_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (i_flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end
  end

  // FIFO registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// tb_uart_tx_buffer: directed checks of uart_tx_buffer, one instance with
// CRLF expansion and one without, sharing the same stimulus.
module tb_uart_tx_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clk_en = 1'b1;
  logic [7:0] wr_data = '0;
  logic       wr_en = 1'b0;
  logic       flush = 1'b0;
  logic       ready = 1'b0;

  logic [7:0] d1_data, d0_data;
  logic       d1_valid, d0_valid;
  logic [4:0] d1_count, d0_count;
  logic       d1_full, d0_full;
  logic       d1_empty, d0_empty;
  logic       d1_ovf, d0_ovf;

  logic [7:0] log1[$];
  logic [7:0] log0[$];
  logic [7:0] exp1[$];
  logic [7:0] exp0[$];

  int n_chk = 0;
  int n_pass = 0;

  uart_tx_buffer #(.DEPTH(16), .CRLF(1'b1)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .i_wr_data(wr_data), .i_wr_en(wr_en), .i_flush(flush),
    .o_data(d1_data), .o_valid(d1_valid), .i_ready(ready),
    .o_count(d1_count), .o_full(d1_full), .o_empty(d1_empty),
    .o_overflow(d1_ovf)
  );

  uart_tx_buffer #(.DEPTH(16), .CRLF(1'b0)) dut_raw (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .i_wr_data(wr_data), .i_wr_en(wr_en), .i_flush(flush),
    .o_data(d0_data), .o_valid(d0_valid), .i_ready(ready),
    .o_count(d0_count), .o_full(d0_full), .o_empty(d0_empty),
    .o_overflow(d0_ovf)
  );

  always #5 clk = ~clk;

  // record every byte that crosses the stream interface
  always @(posedge clk) begin
    if (rst && ready && d1_valid) log1.push_back(d1_data);
    if (rst && ready && d0_valid) log0.push_back(d0_data);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic push(input logic [7:0] b);
    wr_data = b;
    wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_logs();
    log1.delete();
    log0.delete();
    exp1.delete();
    exp0.delete();
  endtask

  task automatic cmp_logs(input string tag);
    check({tag, "_n1"}, log1.size(), exp1.size());
    check({tag, "_n0"}, log0.size(), exp0.size());
    for (int i = 0; i < exp1.size() && i < log1.size(); i++)
      check($sformatf("%s_b1[%0d]", tag, i), log1[i], exp1[i]);
    for (int i = 0; i < exp0.size() && i < log0.size(); i++)
      check($sformatf("%s_b0[%0d]", tag, i), log0[i], exp0[i]);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  initial begin
    // reset state
    cyc(2);
    check("rst_valid", d1_valid, 1'b0);
    check("rst_data", d1_data, 8'h00);
    check("rst_full", d1_full, 1'b0);
    check("rst_empty", d1_empty, 1'b1);
    check("rst_ovf", d1_ovf, 1'b0);
    check("rst_count", d1_count, 5'd0);
    rst = 1'b1;
    cyc(1);

    // pass-through
    clr_logs();
    ready = 1'b1;
    check("pt_idle_valid", d1_valid, 1'b0);
    wr_data = 8'h48;
    wr_en = 1'b1;
    @(negedge clk);
    check("pt_valid", d1_valid, 1'b1);
    check("pt_data0", d1_data, 8'h48);
    wr_data = 8'h69;
    @(negedge clk);
    wr_en = 1'b0;
    check("pt_data1", d1_data, 8'h69);
    @(negedge clk);
    check("pt_count", d1_count, 5'd0);
    check("pt_empty", d1_empty, 1'b1);
    exp1 = '{8'h48, 8'h69};
    exp0 = '{8'h48, 8'h69};
    cmp_logs("pt");

    // backpressure
    clr_logs();
    ready = 1'b0;
    push(8'h41);
    push(8'h42);
    push(8'h43);
    check("bp_data", d1_data, 8'h41);
    check("bp_count", d1_count, 5'd3);
    cyc(2);
    check("bp_hold", d1_data, 8'h41);
    ready = 1'b1;
    @(negedge clk);
    check("bp_d42", d1_data, 8'h42);
    @(negedge clk);
    check("bp_d43", d1_data, 8'h43);
    @(negedge clk);
    check("bp_empty", d1_empty, 1'b1);
    exp1 = '{8'h41, 8'h42, 8'h43};
    exp0 = '{8'h41, 8'h42, 8'h43};
    cmp_logs("bp");

    // full and overflow
    clr_logs();
    ready = 1'b0;
    for (int i = 0; i < 16; i++) push(8'(i));
    check("fo_full", d1_full, 1'b1);
    check("fo_ovf_pre", d1_ovf, 1'b0);
    push(8'h10);
    check("fo_ovf", d1_ovf, 1'b1);
    check("fo_count", d1_count, 5'd16);
    ready = 1'b1;
    cyc(20);
    ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 10) exp1.push_back(8'h0D);
      exp1.push_back(8'(i));
      exp0.push_back(8'(i));
    end
    cmp_logs("fo");
    check("fo_ovf_hold", d1_ovf, 1'b1);
    do_flush();
    check("fo_ovf_clr", d1_ovf, 1'b0);

    // simultaneous push/pop at full
    clr_logs();
    for (int i = 0; i < 16; i++) push(8'h80 + 8'(i));
    check("sp_full", d1_count, 5'd16);
    ready = 1'b1;
    push(8'h55);
    check("sp_count", d1_count, 5'd16);
    check("sp_ovf", d1_ovf, 1'b0);
    cyc(20);
    ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp1.push_back(8'h80 + 8'(i));
      exp0.push_back(8'h80 + 8'(i));
    end
    exp1.push_back(8'h55);
    exp0.push_back(8'h55);
    cmp_logs("sp");

    // CRLF expansion with stall on the CR
    clr_logs();
    push(8'h61);
    push(8'h0A);
    push(8'h62);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check("cr_d0d", d1_data, 8'h0D);
    cyc(2);
    check("cr_hold", d1_data, 8'h0D);
    check("cr_count", d1_count, 5'd2);
    check("cr_raw_d", d0_data, 8'h0A);
    ready = 1'b1;
    cyc(6);
    ready = 1'b0;
    exp1 = '{8'h61, 8'h0D, 8'h0A, 8'h62};
    exp0 = '{8'h61, 8'h0A, 8'h62};
    cmp_logs("cr");

    // clk_en gating and asynchronous reset
    clk_en = 1'b0;
    push(8'h77);
    cyc(1);
    check("ce_count", d1_count, 5'd0);
    check("ce_valid", d1_valid, 1'b0);
    clk_en = 1'b1;
    for (int i = 0; i < 5; i++) push(8'h30 + 8'(i));
    check("ar_valid_pre", d1_valid, 1'b1);
    check("ar_count_pre", d1_count, 5'd5);
    #2;
    rst = 1'b0;
    #1;
    check("ar_valid", d1_valid, 1'b0);
    check("ar_count", d1_count, 5'd0);
    check("ar_data", d1_data, 8'h00);
    @(negedge clk);
    rst = 1'b1;
    cyc(1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
